// File: rtl/sal_ddr_pkg.sv
// Shared DDR controller types: rank refresh states, pending-count width and
// refresh postponement defaults.
package sal_ddr_pkg;

  localparam int PEND_W           = 4;
  localparam int POSTPONE_MAX_DEF = 8;
  localparam int URGENT_TH_DEF    = 6;

  typedef enum logic [1:0] {
    RK_IDLE,
    RK_PEND,
    RK_URGENT,
    RK_BUSY
  } rank_state_e;

  // Staggered first interval: trefi-1-offset, floored at 0.
  function automatic logic [15:0] stagger_preload(input logic [15:0] trefi,
                                                  input logic [31:0] offset);
    logic [31:0] top;
    top = {16'd0, trefi} - 32'd1;
    if (top >= offset) return 16'(top - offset);
    return 16'd0;
  endfunction

endpackage

// File: rtl/sal_ref_rank.sv
// Per-rank refresh tracker: interval countdown, postponed-refresh count and
// tRFC busy window.
module sal_ref_rank
  import sal_ddr_pkg::*;
#(
  parameter int RANK_IDX     = 0,
  parameter int POSTPONE_MAX = POSTPONE_MAX_DEF,
  parameter int URGENT_TH    = URGENT_TH_DEF,
  parameter int STAGGER      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_en,
  input  logic [15:0]       cfg_trefi,
  input  logic [7:0]        cfg_trfc,
  input  logic              gnt,
  output logic              req,
  output logic              urgent,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              err
);

  localparam logic [31:0]       OFFSET = 32'(RANK_IDX * STAGGER);
  localparam logic [PEND_W-1:0] P_MAX  = PEND_W'(POSTPONE_MAX);
  localparam logic [PEND_W-1:0] P_URG  = PEND_W'(URGENT_TH);

  rank_state_e       state, state_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [7:0]        bcnt, bcnt_nxt;
  logic              err_nxt;
  logic              started, started_nxt;
  logic              tick, accept;

  function automatic rank_state_e classify(input logic [PEND_W-1:0] p);
    if (p == '0)    return RK_IDLE;
    if (p >= P_URG) return RK_URGENT;
    return RK_PEND;
  endfunction

  assign req    = ref_en && (state == RK_PEND || state == RK_URGENT);
  assign urgent = ref_en && (state == RK_URGENT);
  assign busy   = (state == RK_BUSY);
  assign tick   = ref_en && (cnt == 16'd0);
  assign accept = gnt && req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RK_IDLE;
      pend    <= '0;
      cnt     <= stagger_preload(cfg_trefi, OFFSET);
      bcnt    <= '0;
      err     <= 1'b0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      bcnt    <= bcnt_nxt;
      err     <= err_nxt;
      started <= started_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    cnt_nxt     = cnt;
    bcnt_nxt    = bcnt;
    err_nxt     = err;
    started_nxt = started | ref_en;

    // Until the first enable the counter tracks the staggered preload; once
    // running, a disable only freezes it so re-enable resumes in place.
    if (!ref_en) begin
      if (!started) cnt_nxt = stagger_preload(cfg_trefi, OFFSET);
    end else if (cnt == 16'd0) begin
      cnt_nxt = cfg_trefi - 16'd1;
    end else begin
      cnt_nxt = cnt - 16'd1;
    end

    if (tick && !accept) begin
      if (pend == P_MAX) err_nxt = 1'b1;
      else               pend_nxt = pend + 1'b1;
    end else if (accept && !tick) begin
      pend_nxt = pend - 1'b1;
    end

    if (accept) begin
      state_nxt = RK_BUSY;
      bcnt_nxt  = cfg_trfc - 8'd1;
    end else if (state == RK_BUSY) begin
      if (bcnt == 8'd0) state_nxt = classify(pend_nxt);
      else              bcnt_nxt  = bcnt - 8'd1;
    end else begin
      state_nxt = classify(pend_nxt);
    end
  end

endmodule

// File: rtl/sal_ref_sched.sv
// Refresh scheduler: one independent sal_ref_rank per rank; the top only
// slices the rank buses and merges the overflow flags.
module sal_ref_sched
  import sal_ddr_pkg::*;
#(
  parameter int NUM_RANK     = 2,
  parameter int POSTPONE_MAX = POSTPONE_MAX_DEF,
  parameter int URGENT_TH    = URGENT_TH_DEF,
  parameter int STAGGER      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_en,
  input  logic [15:0]                cfg_trefi,
  input  logic [7:0]                 cfg_trfc,
  output logic [NUM_RANK-1:0]        ref_req,
  output logic [NUM_RANK-1:0]        ref_urgent,
  input  logic [NUM_RANK-1:0]        ref_gnt,
  output logic [NUM_RANK-1:0]        ref_busy,
  output logic [NUM_RANK*PEND_W-1:0] ref_pend,
  output logic                       ref_err
);

  logic [NUM_RANK-1:0] rank_err;

  for (genvar g = 0; g < NUM_RANK; g++) begin : g_rank
    sal_ref_rank #(
      .RANK_IDX    (g),
      .POSTPONE_MAX(POSTPONE_MAX),
      .URGENT_TH   (URGENT_TH),
      .STAGGER     (STAGGER)
    ) u_rank (
      .clk      (clk),
      .rst      (rst),
      .ref_en   (ref_en),
      .cfg_trefi(cfg_trefi),
      .cfg_trfc (cfg_trfc),
      .gnt      (ref_gnt[g]),
      .req      (ref_req[g]),
      .urgent   (ref_urgent[g]),
      .busy     (ref_busy[g]),
      .pend     (ref_pend[g*PEND_W +: PEND_W]),
      .err      (rank_err[g])
    );
  end

  assign ref_err = |rank_err;

endmodule

// File: tb/tb_sal_ref_sched.sv
// Directed bench for sal_ref_sched: timed expectations go into a scoreboard,
// a negedge monitor retires each one in the cycle it names.
module tb_sal_ref_sched;

  localparam int S_REQ = 0, S_URG = 1, S_BUSY = 2, S_PEND = 3, S_ERR = 4;

  logic       clk = 1'b0;
  logic       rst, ref_en;
  logic [15:0] cfg_trefi;
  logic [7:0] cfg_trfc;
  logic [1:0] ref_req, ref_urgent, ref_gnt, ref_busy;
  logic [7:0] ref_pend;
  logic       ref_err;

  int cyc = 0;
  int base = 0;
  bit done = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  string sname[5] = '{"req", "urgent", "busy", "pend", "err"};

  sal_ref_sched dut (
    .clk       (clk),
    .rst       (rst),
    .ref_en    (ref_en),
    .cfg_trefi (cfg_trefi),
    .cfg_trfc  (cfg_trfc),
    .ref_req   (ref_req),
    .ref_urgent(ref_urgent),
    .ref_gnt   (ref_gnt),
    .ref_busy  (ref_busy),
    .ref_pend  (ref_pend),
    .ref_err   (ref_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sig);
    case (sig)
      S_REQ:   return {30'd0, ref_req};
      S_URG:   return {30'd0, ref_urgent};
      S_BUSY:  return {30'd0, ref_busy};
      S_PEND:  return {24'd0, ref_pend};
      default: return {31'd0, ref_err};
    endcase
  endfunction

  // Expectation for the cycle following edge base+t.
  task automatic chk(input int t, input int sig, input logic [31:0] val);
    exp_t e;
    e.at = base + t; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  task automatic run_to(input int t);
    int guard = 0;
    while (cyc < base + t && guard < 100000) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  // Monitor: retire scoreboard entries due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at <= cyc) begin
          n_chk++;
          if (sb[i].at < cyc || probe(sb[i].sig) !== sb[i].val) begin
            n_fail++;
            $display("FAIL %s@%0d: got %0h, expected %0h", sname[sb[i].sig],
                     sb[i].at - base, probe(sb[i].sig), sb[i].val);
          end
          sb.delete(i);
        end
      end
      if (done) begin
        for (int i = 0; i < sb.size(); i++) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s@%0d: never checked, expected %0h", sname[sb[i].sig],
                   sb[i].at - base, sb[i].val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin
    rst = 1'b1; ref_en = 1'b0; ref_gnt = 2'b00;
    cfg_trefi = 16'd200; cfg_trfc = 8'd20;
    repeat (2) @(posedge clk);
    #1;
    base = cyc;
    rst = 1'b0; ref_en = 1'b1;

    // reset state
    chk(0, S_REQ, 0); chk(0, S_URG, 0); chk(0, S_BUSY, 0); chk(0, S_PEND, 0); chk(0, S_ERR, 0);
    // grant to an idle rank is ignored
    chk(100, S_BUSY, 'h00); chk(100, S_PEND, 'h00);
    // staggered first ticks: rank1 at 136, rank0 at 200
    chk(135, S_PEND, 'h00); chk(136, S_PEND, 'h10); chk(136, S_REQ, 'b10);
    chk(199, S_PEND, 'h10); chk(199, S_REQ, 'b10);
    chk(200, S_PEND, 'h11); chk(200, S_REQ, 'b11);
    // rank0 grant at 202, tRFC 20 sampled at grant despite change at 210
    chk(202, S_BUSY, 'b01); chk(202, S_REQ, 'b10); chk(202, S_PEND, 'h10);
    chk(221, S_BUSY, 'b01); chk(222, S_BUSY, 'b00);
    // rank1 grant coincident with tick at pending 3, tRFC now 10
    chk(736, S_PEND, 'h32); chk(736, S_BUSY, 'b10);
    chk(745, S_BUSY, 'b10); chk(746, S_BUSY, 'b00);
    chk(1000, S_PEND, 'h34);
    // rank0 urgency and overflow
    chk(1399, S_URG, 'b00); chk(1399, S_PEND, 'h35);
    chk(1400, S_URG, 'b01); chk(1400, S_PEND, 'h36); chk(1400, S_REQ, 'b11);
    chk(1799, S_PEND, 'h37); chk(1800, S_PEND, 'h38);
    chk(1999, S_ERR, 0); chk(2000, S_ERR, 1); chk(2000, S_PEND, 'h38);
    // grant to busy rank1 at 1940 is ignored
    chk(1945, S_BUSY, 'b10); chk(1946, S_BUSY, 'b00); chk(1946, S_PEND, 'h38);
    // rank0 grant at 2040, then disable from 2051: tRFC still completes
    chk(2040, S_BUSY, 'b01); chk(2040, S_PEND, 'h37);
    chk(2045, S_URG, 'b00); chk(2045, S_REQ, 'b10);
    chk(2051, S_REQ, 'b00); chk(2051, S_URG, 'b00);
    chk(2059, S_BUSY, 'b01); chk(2060, S_BUSY, 'b00);
    chk(2136, S_PEND, 'h37); chk(2300, S_REQ, 'b00); chk(2300, S_ERR, 1);
    // re-enable after 500 frozen cycles
    chk(2551, S_REQ, 'b11); chk(2551, S_URG, 'b01);
    chk(2635, S_PEND, 'h37); chk(2636, S_PEND, 'h47);
    chk(2699, S_PEND, 'h47); chk(2700, S_PEND, 'h48);
    // reset mid-tRFC
    chk(2710, S_BUSY, 'b01); chk(2710, S_PEND, 'h47); chk(2719, S_BUSY, 'b01);
    chk(2720, S_BUSY, 0); chk(2720, S_PEND, 0); chk(2720, S_ERR, 0);
    chk(2720, S_REQ, 0); chk(2720, S_URG, 0);
    chk(2855, S_PEND, 'h00); chk(2856, S_PEND, 'h10);
    chk(2919, S_PEND, 'h10); chk(2920, S_PEND, 'h11);
    // simultaneous grants
    chk(2930, S_BUSY, 'b11); chk(2930, S_PEND, 'h00); chk(2930, S_REQ, 'b00);
    chk(2949, S_BUSY, 'b11); chk(2950, S_BUSY, 'b00);
    // trefi=300 takes effect at next reload
    chk(3155, S_PEND, 'h00); chk(3156, S_PEND, 'h10);
    chk(3219, S_PEND, 'h10); chk(3220, S_PEND, 'h11);

    run_to(99);  ref_gnt = 2'b01;
    run_to(100); ref_gnt = 2'b00;
    run_to(201); ref_gnt = 2'b01;
    run_to(202); ref_gnt = 2'b00;
    run_to(210); cfg_trfc = 8'd10;
    for (int k = 0; k < 7; k++) begin
      run_to(735 + 200 * k); ref_gnt = 2'b10;
      run_to(736 + 200 * k); ref_gnt = 2'b00;
    end
    run_to(1939); ref_gnt = 2'b10;
    run_to(1940); ref_gnt = 2'b00;
    run_to(2000); cfg_trfc = 8'd20;
    run_to(2039); ref_gnt = 2'b01;
    run_to(2040); ref_gnt = 2'b00;
    run_to(2050); ref_en = 1'b0;
    run_to(2550); ref_en = 1'b1;
    run_to(2709); ref_gnt = 2'b01;
    run_to(2710); ref_gnt = 2'b00;
    run_to(2719); rst = 1'b1;
    run_to(2720); rst = 1'b0;
    run_to(2800); cfg_trefi = 16'd300;
    run_to(2929); ref_gnt = 2'b11;
    run_to(2930); ref_gnt = 2'b00;
    run_to(3221);
    done = 1'b1;
  end

endmodule
